// File: rtl/phase2speed_mc_if.sv
// Sample/result bundle for phase2speed_mc: the phase-sample side plus the tagged speed result.
interface phase2speed_mc_if #(
  parameter int NCH = 4,
  parameter int PW  = 19,
  parameter int SW  = 16
);
  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;

  logic                 clear;
  logic                 sample;
  logic [CW-1:0]        ch;
  logic [3:0]           meanlen;
  logic signed [PW-1:0] phase;
  logic signed [SW-1:0] speed;
  logic [CW-1:0]        speed_ch;
  logic                 ready;

  modport master (output clear, sample, ch, meanlen, phase,
                  input  speed, speed_ch, ready);
  modport slave  (input  clear, sample, ch, meanlen, phase,
                  output speed, speed_ch, ready);
endinterface

// File: rtl/phase2speed_mc.sv
// Per-channel windowed averaging of phase differences, gain-scaled into tagged speed results.
// Optional macro SPEED_SAT_EN: saturate the speed output instead of two's-complement wrapping.
module phase2speed_mc #(
  parameter int NCH    = 4,
  parameter int PW     = 19,
  parameter int SW     = 16,
  parameter int MAXLEN = 15,
  parameter int KW     = 16,
  parameter int K      = 1024,
  parameter int KSHIFT = 10
) (
  input  logic            clock,
  input  logic            reset,
  phase2speed_mc_if.slave bus
);
  localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int AW  = PW + MAXLEN;
  localparam int PRW = AW + KW;
  localparam logic [3:0]           MAXLEN_L = 4'(MAXLEN);
  localparam logic signed [KW-1:0] K_L      = KW'(K);

  function automatic logic signed [SW-1:0] fit(input logic signed [PRW-1:0] p);
`ifdef SPEED_SAT_EN
    if ((&p[PRW-1:SW-1]) || !(|p[PRW-1:SW-1])) begin
      fit = p[SW-1:0];
    end else if (p[PRW-1]) begin
      fit = {1'b1, {(SW-1){1'b0}}};
    end else begin
      fit = {1'b0, {(SW-1){1'b1}}};
    end
`else
    fit = p[SW-1:0];
`endif
  endfunction

  logic signed [AW-1:0]  acc_q [NCH];
  logic signed [AW-1:0]  acc_d [NCH];
  logic [MAXLEN-1:0]     cnt_q [NCH];
  logic [MAXLEN-1:0]     cnt_d [NCH];
  logic [3:0]            len_q [NCH];
  logic [3:0]            len_d [NCH];
  logic                  s1_vld_q, s1_vld_d;
  logic signed [AW-1:0]  s1_mean_q, s1_mean_d;
  logic [CW-1:0]         s1_ch_q, s1_ch_d;
  logic signed [SW-1:0]  speed_q, speed_d;
  logic [CW-1:0]         speed_ch_q, speed_ch_d;
  logic                  ready_q, ready_d;

  logic                  accept_s;
  logic                  close_s;
  logic [3:0]            eff_len_s;
  logic signed [AW-1:0]  sum_s;
  logic signed [PRW-1:0] prod_s;
  logic signed [PRW-1:0] p_s;

  // Window length is taken from meanlen only when the window opens; otherwise the latched value rules.
  always_comb begin
    accept_s  = bus.sample && (32'(bus.ch) < NCH);
    eff_len_s = len_q[bus.ch];
    if (cnt_q[bus.ch] == '0) begin
      if (bus.meanlen > MAXLEN_L) begin
        eff_len_s = MAXLEN_L;
      end else begin
        eff_len_s = bus.meanlen;
      end
    end else begin
      eff_len_s = len_q[bus.ch];
    end
    sum_s   = acc_q[bus.ch] + AW'(bus.phase);
    close_s = accept_s && (32'(cnt_q[bus.ch]) == ((32'd1 << eff_len_s) - 32'd1));
    prod_s  = PRW'(s1_mean_q) * PRW'(K_L);
    p_s     = prod_s >>> KSHIFT;
  end

  always_comb begin
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    len_d      = len_q;
    s1_vld_d   = 1'b0;
    s1_mean_d  = s1_mean_q;
    s1_ch_d    = s1_ch_q;
    speed_d    = speed_q;
    speed_ch_d = speed_ch_q;
    ready_d    = 1'b0;
    if (bus.clear) begin
      // Flush wins over any sample in the same cycle; the last result stays visible.
      for (int i = 0; i < NCH; i++) begin
        acc_d[i] = '0;
        cnt_d[i] = '0;
        len_d[i] = 4'd0;
      end
    end else begin
      if (accept_s) begin
        len_d[bus.ch] = eff_len_s;
        if (close_s) begin
          s1_vld_d      = 1'b1;
          s1_mean_d     = sum_s >>> eff_len_s;
          s1_ch_d       = bus.ch;
          acc_d[bus.ch] = '0;
          cnt_d[bus.ch] = '0;
        end else begin
          acc_d[bus.ch] = sum_s;
          cnt_d[bus.ch] = cnt_q[bus.ch] + {{(MAXLEN-1){1'b0}}, 1'b1};
        end
      end else begin
        s1_vld_d = 1'b0;
      end
      if (s1_vld_q) begin
        ready_d    = 1'b1;
        speed_d    = fit(p_s);
        speed_ch_d = s1_ch_q;
      end else begin
        ready_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NCH; i++) begin
        acc_q[i] <= '0;
        cnt_q[i] <= '0;
        len_q[i] <= 4'd0;
      end
      s1_vld_q   <= 1'b0;
      s1_mean_q  <= '0;
      s1_ch_q    <= '0;
      speed_q    <= '0;
      speed_ch_q <= '0;
      ready_q    <= 1'b0;
    end else begin
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      len_q      <= len_d;
      s1_vld_q   <= s1_vld_d;
      s1_mean_q  <= s1_mean_d;
      s1_ch_q    <= s1_ch_d;
      speed_q    <= speed_d;
      speed_ch_q <= speed_ch_d;
      ready_q    <= ready_d;
    end
  end

  assign bus.speed    = speed_q;
  assign bus.speed_ch = speed_ch_q;
  assign bus.ready    = ready_q;
endmodule

// File: tb/tb_phase2speed_mc.sv
// Randomized and directed bench for phase2speed_mc against a window-sum reference model.
module tb_phase2speed_mc;
  localparam int NCH = 4;

  typedef struct {
    int     due;
    int     ch;
    longint spd;
  } res_t;

  logic clock;
  logic reset;
  int   n_checks;
  int   n_errors;
  int   edge_cnt;

  longint m_sum [NCH];
  int     m_cnt [NCH];
  int     m_len [NCH];
  res_t   pend [$];
  longint last_speed;
  int     last_ch;

  phase2speed_mc_if bus ();

  phase2speed_mc dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_val(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %0d expected %0d (edge %0d)", tag, obs, exp, edge_cnt);
    end
  endtask

  function automatic longint fdiv(input longint a, input longint d);
    longint q;
    q = a / d;
    if ((a % d != 0) && (a < 0)) q = q - 1;
    return q;
  endfunction

  function automatic longint fit_model(input longint p);
    longint w;
`ifdef SPEED_SAT_EN
    if (p > 32767) return 32767;
    if (p < -32768) return -32768;
    return p;
`else
    w = p & 64'hFFFF;
    if (w >= 32768) w = w - 65536;
    return w;
`endif
  endfunction

  task automatic model_clear();
    for (int i = 0; i < NCH; i++) begin
      m_sum[i] = 0;
      m_cnt[i] = 0;
      m_len[i] = 0;
    end
    pend.delete();
  endtask

  // Apply one input cycle to the model and DUT, then check outputs after the edge.
  task automatic cyc(input bit smp, input int c, input int ml, input int ph, input bit clr);
    longint mean;
    res_t   r;
    bit     exp_rdy;
    bus.sample  = smp;
    bus.ch      = 2'(c);
    bus.meanlen = 4'(ml);
    bus.phase   = 19'(ph);
    bus.clear   = clr;
    if (clr) begin
      model_clear();
    end else if (smp && c < NCH) begin
      if (m_cnt[c] == 0) m_len[c] = (ml > 15) ? 15 : ml;
      m_sum[c] += ph;
      m_cnt[c]++;
      if (m_cnt[c] == (1 << m_len[c])) begin
        mean  = fdiv(m_sum[c], longint'(1) << m_len[c]);
        r.due = edge_cnt + 2;
        r.ch  = c;
        r.spd = fit_model(fdiv(mean * 1024, 1024));
        pend.push_back(r);
        m_sum[c] = 0;
        m_cnt[c] = 0;
      end
    end
    @(negedge clock);
    edge_cnt++;
    exp_rdy = 1'b0;
    if (pend.size() > 0) begin
      if (pend[0].due == edge_cnt) begin
        exp_rdy    = 1'b1;
        last_speed = pend[0].spd;
        last_ch    = pend[0].ch;
        void'(pend.pop_front());
      end
    end
    check_val("ready", longint'(bus.ready), longint'(exp_rdy));
    check_val("speed", longint'(bus.speed), last_speed);
    check_val("speed_ch", longint'(bus.speed_ch), longint'(last_ch));
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    #1;
    model_clear();
    last_speed = 0;
    last_ch    = 0;
    check_val("rst_ready", longint'(bus.ready), 0);
    check_val("rst_speed", longint'(bus.speed), 0);
    check_val("rst_ch", longint'(bus.speed_ch), 0);
    #1;
    reset = 1'b1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 0, 0, 0, 1'b0);
  endtask

  initial begin
    int c, ml, ph;
    n_checks = 0;
    n_errors = 0;
    edge_cnt = 0;
    last_speed = 0;
    last_ch = 0;
    model_clear();
    bus.sample = 1'b0; bus.ch = 2'd0; bus.meanlen = 4'd0; bus.phase = 19'd0; bus.clear = 1'b0;
    reset = 1'b0;
    #1;
    check_val("rst_ready", longint'(bus.ready), 0);
    check_val("rst_speed", longint'(bus.speed), 0);
    @(negedge clock);
    reset = 1'b1;

    // Average of four on ch0
    cyc(1, 0, 2, 100, 0); cyc(1, 0, 2, 200, 0); cyc(1, 0, 2, 300, 0); cyc(1, 0, 2, 400, 0);
    idle(3);
    check_val("t1_speed", longint'(bus.speed), 250);
    // Interleaved channels
    cyc(1, 1, 1, 10, 0); cyc(1, 2, 1, -4, 0); cyc(1, 1, 1, 30, 0); cyc(1, 2, 1, -8, 0);
    idle(3);
    check_val("t2_speed", longint'(bus.speed), -6);
    // Floor of negative mean
    cyc(1, 3, 1, -1, 0); cyc(1, 3, 1, -2, 0);
    idle(2);
    check_val("t3_speed", longint'(bus.speed), -2);
    // Pass-through at the positive phase extreme
    cyc(1, 0, 0, 262143, 0);
    idle(2);
`ifdef SPEED_SAT_EN
    check_val("t4_speed", longint'(bus.speed), 32767);
`else
    check_val("t4_speed", longint'(bus.speed), -1);
`endif
    // Reset discards a partial window
    cyc(1, 0, 2, 555, 0); cyc(1, 0, 2, 777, 0);
    pulse_reset();
    cyc(1, 0, 2, 100, 0); cyc(1, 0, 2, 200, 0); cyc(1, 0, 2, 300, 0); cyc(1, 0, 2, 400, 0);
    idle(3);
    check_val("t5_speed", longint'(bus.speed), 250);
    // meanlen change mid-window applies to the following window
    cyc(1, 0, 1, 8, 0); cyc(1, 0, 2, 12, 0);
    cyc(1, 0, 2, 1, 0); cyc(1, 0, 2, 2, 0); cyc(1, 0, 2, 3, 0); cyc(1, 0, 2, 6, 0);
    idle(3);
    // Clear flushes partial sums and an in-flight result
    cyc(1, 1, 1, 50, 0); cyc(1, 1, 1, 70, 1); cyc(1, 1, 1, 90, 0); cyc(1, 1, 1, 110, 0);
    cyc(1, 2, 0, 33, 0); cyc(0, 0, 0, 0, 1);
    idle(3);

    // Randomized traffic with occasional clear and one reset
    for (int i = 0; i < 600; i++) begin
      c  = int'($urandom_range(0, NCH - 1));
      ml = int'($urandom_range(0, 3));
      ph = int'($urandom_range(0, 524287)) - 262144;
      if (i == 300) pulse_reset();
      cyc(($urandom_range(0, 9) < 7), c, ml, ph, ($urandom_range(0, 49) == 0));
    end
    idle(4);
    check_val("pend_empty", longint'(pend.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
